// File: rtl/sram_broadcaster.sv
// sram_broadcaster: sweeps an SRAM word window for a programmable number of passes and
// broadcasts each word with its address one cycle after the read is issued.
// Latency: read in cycle N appears on o_data/o_addr/o_data_valid in cycle N+1.
// Backpressure: i_stall suppresses new reads in READ; the read already in flight
// still reaches the bus.
// Ports: i_clk/i_nrst/i_reg_clear control; i_start + window/pass inputs (latched in IDLE);
// o_sram_rd_en/o_sram_addr/i_sram_data SRAM side; o_data/o_addr/o_data_valid broadcast;
// o_busy (READ, DRAIN), o_done (one-cycle completion pulse).
module sram_broadcaster #(
  parameter int SRAM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8,
  parameter int PASS_WIDTH      = 4
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic                       i_reg_clear,
  input  logic                       i_start,
  input  logic [ADDR_WIDTH-1:0]      i_start_addr,
  input  logic [ADDR_WIDTH-1:0]      i_end_addr,
  input  logic [PASS_WIDTH-1:0]      i_num_passes,
  input  logic                       i_stall,
  output logic                       o_sram_rd_en,
  output logic [ADDR_WIDTH-1:0]      o_sram_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] i_sram_data,
  output logic [SRAM_DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0]      o_addr,
  output logic                       o_data_valid,
  output logic                       o_busy,
  output logic                       o_done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [PASS_WIDTH-1:0] PASS_ONE = 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0]   start_addr_q, start_addr_d;
  logic [ADDR_WIDTH-1:0]   end_addr_q, end_addr_d;
  logic [PASS_WIDTH-1:0]   passes_q, passes_d;
  logic                    bc_vld_q, bc_vld_d;
  logic [ADDR_WIDTH-1:0]   bc_addr_q, bc_addr_d;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      passes_q     <= '0;
      bc_vld_q     <= 1'b0;
      bc_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      passes_q     <= passes_d;
      bc_vld_q     <= bc_vld_d;
      bc_addr_q    <= bc_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    passes_d     = passes_q;
    rd_en        = 1'b0;
    rd_addr      = '0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          start_addr_d = i_start_addr;
          end_addr_d   = i_end_addr;
          cur_addr_d   = i_start_addr;
          passes_d     = (i_num_passes == '0) ? PASS_ONE : i_num_passes;
          state_d      = S_READ;
        end
      end
      S_READ: begin
        if (!i_stall) begin
          rd_en   = 1'b1;
          rd_addr = cur_addr_q;
          if (cur_addr_q == end_addr_q) begin
            // Next pass restarts immediately so passes run back to back.
            if (passes_q > PASS_ONE) begin
              passes_d   = passes_q - PASS_ONE;
              cur_addr_d = start_addr_q;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            // Natural modulo wrap lets a window straddle the top of the address space.
            cur_addr_d = cur_addr_q + ADDR_ONE;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    bc_vld_d  = rd_en;
    bc_addr_d = rd_addr;

    // Synchronous clear behaves like reset: the in-flight read is dropped too.
    if (i_reg_clear) begin
      state_d      = S_IDLE;
      cur_addr_d   = '0;
      start_addr_d = '0;
      end_addr_d   = '0;
      passes_d     = '0;
      bc_vld_d     = 1'b0;
      bc_addr_d    = '0;
    end
  end

  assign o_sram_rd_en = rd_en;
  assign o_sram_addr  = rd_addr;
  assign o_data_valid = bc_vld_q;
  assign o_addr       = bc_addr_q;
  assign o_data       = bc_vld_q ? i_sram_data : '0;
  assign o_busy       = (state_q == S_READ) || (state_q == S_DRAIN);
  assign o_done       = (state_q == S_DONE);

endmodule

// File: tb/tb_sram_broadcaster.sv
// Testbench for sram_broadcaster: directed sweeps with literal expectations plus a
// randomized run, all checked every cycle against a queue-based model of the read stream.
module tb_sram_broadcaster;

  logic        clk = 1'b0;
  logic        i_nrst, i_reg_clear, i_start, i_stall;
  logic [7:0]  i_start_addr, i_end_addr;
  logic [3:0]  i_num_passes;
  logic        o_sram_rd_en, o_data_valid, o_busy, o_done;
  logic [7:0]  o_sram_addr, o_addr;
  logic [63:0] i_sram_data, o_data;

  sram_broadcaster #(.SRAM_DATA_WIDTH(64), .ADDR_WIDTH(8), .PASS_WIDTH(4)) dut (
    .i_clk(clk), .i_nrst(i_nrst), .i_reg_clear(i_reg_clear), .i_start(i_start),
    .i_start_addr(i_start_addr), .i_end_addr(i_end_addr), .i_num_passes(i_num_passes),
    .i_stall(i_stall), .o_sram_rd_en(o_sram_rd_en), .o_sram_addr(o_sram_addr),
    .i_sram_data(i_sram_data), .o_data(o_data), .o_addr(o_addr),
    .o_data_valid(o_data_valid), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // SRAM: one-cycle read latency; returns junk when not read so output gating is exercised.
  logic [63:0] mem [256];
  logic [63:0] sram_q = '0;
  always @(posedge clk) sram_q <= o_sram_rd_en ? mem[o_sram_addr] : {$urandom, $urandom};
  assign i_sram_data = sram_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  // Per-run event logs (cycle relative to the start cycle) of what the DUT did.
  int t0 = 0;
  int lr_c[$], lr_a[$], lv_c[$], lv_a[$];
  int n_done = 0;
  int done_rel = -1;

  // Model: a sweep is the list of addresses still to be read; the bus shows last cycle's read.
  localparam int M_IDLE = 0, M_READ = 1, M_DRAIN = 2, M_DONE = 3;
  int          m_phase = M_IDLE;
  int          m_q[$];
  logic        m_prv_rd = 1'b0;
  logic [7:0]  m_prv_addr = '0;

  always @(negedge clk) begin
    logic        e_rd, e_busy, e_done;
    logic [7:0]  e_sa;
    logic [63:0] e_data;
    int n, len, rel;
    if (!i_nrst) begin
      m_phase = M_IDLE; m_q.delete(); m_prv_rd = 1'b0; m_prv_addr = '0;
    end
    e_rd   = (m_phase == M_READ) && !i_stall;
    e_sa   = e_rd ? 8'(m_q[0]) : 8'd0;
    e_data = m_prv_rd ? mem[m_prv_addr] : 64'd0;
    e_busy = (m_phase == M_READ) || (m_phase == M_DRAIN);
    e_done = (m_phase == M_DONE);
    chk("rd_en",     64'(o_sram_rd_en), 64'(e_rd));
    chk("sram_addr", 64'(o_sram_addr),  64'(e_sa));
    chk("valid",     64'(o_data_valid), 64'(m_prv_rd));
    chk("bus_addr",  64'(o_addr),       64'(m_prv_addr));
    chk("bus_data",  o_data,            e_data);
    chk("busy",      64'(o_busy),       64'(e_busy));
    chk("done",      64'(o_done),       64'(e_done));

    rel = cnt - t0;
    if (o_sram_rd_en) begin lr_c.push_back(rel); lr_a.push_back(int'(o_sram_addr)); end
    if (o_data_valid) begin lv_c.push_back(rel); lv_a.push_back(int'(o_addr)); end
    if (o_done) begin n_done++; done_rel = rel; end

    if (i_nrst) begin
      if (i_reg_clear) begin
        m_phase = M_IDLE; m_q.delete(); m_prv_rd = 1'b0; m_prv_addr = '0;
      end else begin
        m_prv_rd = e_rd; m_prv_addr = e_sa;
        case (m_phase)
          M_IDLE: if (i_start) begin
            n   = (i_num_passes == 0) ? 1 : int'(i_num_passes);
            len = (int'(i_end_addr) - int'(i_start_addr) + 256) % 256 + 1;
            for (int p = 0; p < n; p++)
              for (int k = 0; k < len; k++) m_q.push_back((int'(i_start_addr) + k) % 256);
            m_phase = M_READ;
          end
          M_READ: if (e_rd) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_phase = M_DRAIN;
          end
          M_DRAIN: m_phase = M_DONE;
          default: m_phase = M_IDLE;
        endcase
      end
    end
  end

  task automatic idle_inputs();
    i_start = 1'b0; i_stall = 1'b0; i_reg_clear = 1'b0;
    i_start_addr = '0; i_end_addr = '0; i_num_passes = '0;
  endtask

  // Start in cycle 0, then run ncyc cycles; window inputs scramble after the latch.
  task automatic run_seq(input logic [7:0] s, input logic [7:0] e, input logic [3:0] p,
                         input int st_lo, input int st_hi, input int clr_c,
                         input int rs_a, input int rs_b, input int ncyc);
    lr_c.delete(); lr_a.delete(); lv_c.delete(); lv_a.delete();
    n_done = 0; done_rel = -1;
    @(posedge clk); #1;
    t0 = cnt;
    i_start = 1'b1; i_start_addr = s; i_end_addr = e; i_num_passes = p;
    i_stall = 1'b0; i_reg_clear = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      i_start      = (c == rs_a) || (c == rs_b);
      i_start_addr = 8'($urandom);
      i_end_addr   = 8'($urandom);
      i_num_passes = 4'($urandom);
      i_stall      = (c >= st_lo) && (c <= st_hi);
      i_reg_clear  = (c == clr_c);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    i_nrst = 1'b0;
    idle_inputs();
    #2;
    chk("rst_rd_en", 64'(o_sram_rd_en), 64'd0);
    chk("rst_valid", 64'(o_data_valid), 64'd0);
    chk("rst_busy",  64'(o_busy),       64'd0);
    chk("rst_done",  64'(o_done),       64'd0);
    chk("rst_data",  o_data,            64'd0);
    repeat (2) @(posedge clk);
    #1 i_nrst = 1'b1;
    repeat (2) @(posedge clk);

    // Basic sweep 4..7, one pass.
    run_seq(8'd4, 8'd7, 4'd1, -1, -1, -1, -1, -1, 8);
    chk("basic_nrd", 64'(lr_c.size()), 64'd4);
    if (lr_c.size() == 4) begin
      chk("basic_rd0_cyc", 64'(lr_c[0]), 64'd1); chk("basic_rd0_adr", 64'(lr_a[0]), 64'd4);
      chk("basic_rd3_cyc", 64'(lr_c[3]), 64'd4); chk("basic_rd3_adr", 64'(lr_a[3]), 64'd7);
    end
    chk("basic_nvld", 64'(lv_c.size()), 64'd4);
    if (lv_c.size() == 4) begin
      chk("basic_vld0_cyc", 64'(lv_c[0]), 64'd2); chk("basic_vld3_cyc", 64'(lv_c[3]), 64'd5);
    end
    chk("basic_done_cyc", 64'(done_rel), 64'd6);
    chk("basic_ndone", 64'(n_done), 64'd1);

    // Three passes 0..2 back to back.
    run_seq(8'd0, 8'd2, 4'd3, -1, -1, -1, -1, -1, 13);
    chk("multi_nrd", 64'(lr_c.size()), 64'd9);
    if (lr_c.size() == 9) begin
      chk("multi_rd3_adr", 64'(lr_a[3]), 64'd0);
      chk("multi_rd8_cyc", 64'(lr_c[8]), 64'd9);
    end
    chk("multi_done_cyc", 64'(done_rel), 64'd11);

    // Zero passes behaves as one.
    run_seq(8'd4, 8'd7, 4'd0, -1, -1, -1, -1, -1, 8);
    chk("p0_nrd", 64'(lr_c.size()), 64'd4);
    chk("p0_done_cyc", 64'(done_rel), 64'd6);

    // Stall in cycles 2-3.
    run_seq(8'd4, 8'd7, 4'd1, 2, 3, -1, -1, -1, 10);
    chk("stall_nrd", 64'(lr_c.size()), 64'd4);
    if (lr_c.size() == 4) begin
      chk("stall_rd1_cyc", 64'(lr_c[1]), 64'd4); chk("stall_rd1_adr", 64'(lr_a[1]), 64'd5);
      chk("stall_rd3_cyc", 64'(lr_c[3]), 64'd6);
    end
    chk("stall_nvld", 64'(lv_c.size()), 64'd4);
    if (lv_c.size() == 4) begin
      chk("stall_vld0_cyc", 64'(lv_c[0]), 64'd2); chk("stall_vld1_cyc", 64'(lv_c[1]), 64'd5);
    end
    chk("stall_done_cyc", 64'(done_rel), 64'd8);

    // Window wrapping past the top of the address space.
    run_seq(8'd254, 8'd1, 4'd1, -1, -1, -1, -1, -1, 8);
    chk("wrap_nrd", 64'(lr_c.size()), 64'd4);
    if (lr_c.size() == 4) begin
      chk("wrap_rd1_adr", 64'(lr_a[1]), 64'd255);
      chk("wrap_rd2_adr", 64'(lr_a[2]), 64'd0);
      chk("wrap_rd3_adr", 64'(lr_a[3]), 64'd1);
    end

    // Single-word window, two passes.
    run_seq(8'd9, 8'd9, 4'd2, -1, -1, -1, -1, -1, 6);
    chk("single_nrd", 64'(lr_c.size()), 64'd2);
    if (lr_c.size() == 2) chk("single_rd1_adr", 64'(lr_a[1]), 64'd9);
    chk("single_done_cyc", 64'(done_rel), 64'd4);

    // Synchronous clear in cycle 3 aborts the sweep with no done.
    run_seq(8'd4, 8'd7, 4'd1, -1, -1, 3, -1, -1, 8);
    chk("clr_nrd", 64'(lr_c.size()), 64'd3);
    chk("clr_ndone", 64'(n_done), 64'd0);
    run_seq(8'd4, 8'd7, 4'd1, -1, -1, -1, -1, -1, 8);
    chk("clr_fresh_done", 64'(done_rel), 64'd6);

    // Start pulses in READ and DONE are ignored.
    run_seq(8'd4, 8'd7, 4'd1, -1, -1, -1, 2, 6, 12);
    chk("rs_nrd", 64'(lr_c.size()), 64'd4);
    chk("rs_ndone", 64'(n_done), 64'd1);

    // Async reset mid-cycle clears outputs immediately.
    @(posedge clk); #1;
    i_start = 1'b1; i_start_addr = 8'd4; i_end_addr = 8'd7; i_num_passes = 4'd1;
    @(posedge clk); #1 i_start = 1'b0;
    @(posedge clk); #2;
    chk("arst_pre_busy", 64'(o_busy), 64'd1);
    i_nrst = 1'b0;
    #1;
    chk("arst_rd_en", 64'(o_sram_rd_en), 64'd0);
    chk("arst_valid", 64'(o_data_valid), 64'd0);
    chk("arst_busy",  64'(o_busy),       64'd0);
    chk("arst_data",  o_data,            64'd0);
    @(posedge clk); #1 i_nrst = 1'b1;
    run_seq(8'd4, 8'd7, 4'd1, -1, -1, -1, -1, -1, 8);
    chk("arst_fresh_done", 64'(done_rel), 64'd6);

    // Randomized traffic, including clears and occasional async resets.
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      i_nrst       = ($urandom_range(0, 499) != 0);
      i_start      = ($urandom_range(0, 7) == 0);
      i_start_addr = 8'($urandom);
      i_end_addr   = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                                 : 8'(i_start_addr + 8'($urandom_range(0, 12)));
      i_num_passes = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      i_stall      = ($urandom_range(0, 3) == 0);
      i_reg_clear  = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    i_nrst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
